// File: rtl/usr_param_if.sv
// Bundles the control, data and status signals of the universal shift register.
// The master modport drives the controls. The slave modport drives q, the serial taps, busy and done.
interface usr_param_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             serial_in_left;
    logic             serial_in_right;
    logic [AMT_W-1:0] amt;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             serial_out_right;
    logic             serial_out_left;
    logic             busy;
    logic             done;

    modport master (
        output mode, data_in, serial_in_left, serial_in_right, amt, dir,
        input  q, serial_out_right, serial_out_left, busy, done
    );

    modport slave (
        input  mode, data_in, serial_in_left, serial_in_right, amt, dir,
        output q, serial_out_right, serial_out_left, busy, done
    );
endinterface

// File: rtl/usr_param.sv
// WIDTH-bit universal shift register. It supports hold, shift, rotate, arithmetic-shift-right and load in one cycle.
// It also runs a burst shift of amt positions with busy/done, and the optional USR_PARITY_EN macro adds a registered parity output.
module usr_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    usr_param_if.slave bus
`ifdef USR_PARITY_EN
    ,
    output logic      parity
`endif
);
    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (bus.mode)
                    3'b001: w_q_nxt = {bus.serial_in_left, r_q[WIDTH-1:1]};
                    3'b010: w_q_nxt = {r_q[WIDTH-2:0], bus.serial_in_right};
                    3'b011: w_q_nxt = bus.data_in;
                    3'b100: w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                    3'b101: w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    3'b110: w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    3'b111: begin
                        // The capture cycle only latches amt and dir. A zero-length burst completes immediately.
                        w_cnt_nxt = bus.amt;
                        w_dir_nxt = bus.dir;
                        if (bus.amt == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_BURST;
                        end
                    end
                    default: w_q_nxt = r_q;
                endcase
            end
            ST_BURST: begin
                w_q_nxt   = r_dir ? {r_q[WIDTH-2:0], bus.serial_in_right}
                                  : {bus.serial_in_left, r_q[WIDTH-1:1]};
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.q                = r_q;
    assign bus.serial_out_right = r_q[0];
    assign bus.serial_out_left  = r_q[WIDTH-1];
    assign bus.busy             = (r_state == ST_BURST);
    assign bus.done             = r_done;

`ifdef USR_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_q_nxt;
        end
    end

    assign parity = r_parity;
`endif
endmodule

// File: tb/tb_usr_param.sv
// Directed bench for usr_param at WIDTH=8, with expected values computed by hand.
module tb_usr_param;
    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    usr_param_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

`ifdef USR_PARITY_EN
    logic parity;
    usr_param #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .parity(parity)
    );
`else
    usr_param #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    // Advance one edge and settle. Inputs change and outputs are sampled 1ns after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.mode = 3'b011;
        bus.data_in = v;
        step();
        bus.mode = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 3'b011;
        bus.data_in = 8'hFF;
        step();
        step();
        tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h expected 00", bus.q); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        bus.data_in = 8'hA5;
        step();
        tests++; if (bus.q !== 8'hA5) begin fails++; $display("FAIL reset_load: got %h expected a5", bus.q); end
        bus.mode = 3'b000;
    endtask

    task automatic test_single();
        bus.mode = 3'b001; bus.serial_in_left = 1'b1;
        step();
        tests++; if (bus.q !== 8'hD2) begin fails++; $display("FAIL shr: got %h expected d2", bus.q); end
        tests++; if (bus.serial_out_left !== 1'b1 || bus.serial_out_right !== 1'b0) begin
            fails++; $display("FAIL taps: got %b%b expected 10", bus.serial_out_left, bus.serial_out_right); end
        load(8'hA5);
        bus.mode = 3'b010; bus.serial_in_right = 1'b0;
        step();
        tests++; if (bus.q !== 8'h4A) begin fails++; $display("FAIL shl: got %h expected 4a", bus.q); end
        load(8'hA5);
        bus.mode = 3'b100;
        step();
        tests++; if (bus.q !== 8'hD2) begin fails++; $display("FAIL rotr: got %h expected d2", bus.q); end
        bus.mode = 3'b101;
        step();
        tests++; if (bus.q !== 8'hA5) begin fails++; $display("FAIL rotl: got %h expected a5", bus.q); end
        load(8'h85);
        bus.mode = 3'b110;
        step();
        tests++; if (bus.q !== 8'hC2) begin fails++; $display("FAIL asr: got %h expected c2", bus.q); end
        bus.mode = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (bus.q !== 8'hC2) begin fails++; $display("FAIL hold%0d: got %h expected c2", i, bus.q); end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h40; exp_q[1] = 8'h20; exp_q[2] = 8'h10;
        load(8'h81);
        bus.mode = 3'b111; bus.amt = 4'd3; bus.dir = 1'b0; bus.serial_in_left = 1'b0;
        step();
        tests++; if (bus.q !== 8'h81 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++; $display("FAIL burst_capture: got q=%h busy=%b done=%b expected 81 1 0", bus.q, bus.busy, bus.done); end
        bus.mode = 3'b011; bus.data_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (bus.q !== exp_q[i] || bus.busy !== (i < 2) || bus.done !== (i == 2)) begin
                fails++; $display("FAIL burst_shift%0d: got q=%h busy=%b done=%b expected %h %b %b",
                                  i, bus.q, bus.busy, bus.done, exp_q[i], (i < 2), (i == 2)); end
        end
        bus.mode = 3'b000;
        step();
        tests++; if (bus.q !== 8'h10 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL burst_after: got q=%h busy=%b done=%b expected 10 0 0", bus.q, bus.busy, bus.done); end
    endtask

    task automatic test_burst_zero();
        load(8'h3C);
        bus.mode = 3'b111; bus.amt = 4'd0;
        step();
        bus.mode = 3'b000;
        tests++; if (bus.q !== 8'h3C || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            fails++; $display("FAIL zero_capture: got q=%h busy=%b done=%b expected 3c 0 1", bus.q, bus.busy, bus.done); end
        step();
        tests++; if (bus.q !== 8'h3C || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL zero_after: got q=%h busy=%b done=%b expected 3c 0 0", bus.q, bus.busy, bus.done); end
    endtask

    task automatic test_burst_long();
        logic [7:0] exp;
        load(8'h00);
        bus.mode = 3'b111; bus.amt = 4'd10; bus.dir = 1'b1; bus.serial_in_right = 1'b1;
        step();
        bus.mode = 3'b000;
        exp = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            exp = {exp[6:0], 1'b1};
            step();
            tests++; if (bus.q !== exp || bus.busy !== (i < 10) || bus.done !== (i == 10)) begin
                fails++; $display("FAIL long_shift%0d: got q=%h busy=%b done=%b expected %h %b %b",
                                  i, bus.q, bus.busy, bus.done, exp, (i < 10), (i == 10)); end
        end
    endtask

    task automatic test_back_to_back();
        load(8'h0F);
        bus.mode = 3'b111; bus.amt = 4'd1; bus.dir = 1'b1; bus.serial_in_right = 1'b0;
        step();
        bus.dir = 1'b0; bus.serial_in_left = 1'b1;
        step();
        tests++; if (bus.q !== 8'h1E || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL b2b_first: got q=%h busy=%b done=%b expected 1e 0 1", bus.q, bus.busy, bus.done); end
        step();
        bus.mode = 3'b000;
        tests++; if (bus.q !== 8'h1E || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++; $display("FAIL b2b_restart: got q=%h busy=%b done=%b expected 1e 1 0", bus.q, bus.busy, bus.done); end
        step();
        tests++; if (bus.q !== 8'h8F || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL b2b_second: got q=%h busy=%b done=%b expected 8f 0 1", bus.q, bus.busy, bus.done); end
    endtask

    task automatic test_reset_mid();
        load(8'h55);
        bus.mode = 3'b111; bus.amt = 4'd5; bus.dir = 1'b0; bus.serial_in_left = 1'b1;
        step();
        bus.mode = 3'b000;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL midrst: got q=%h busy=%b done=%b expected 00 0 0", bus.q, bus.busy, bus.done); end
        for (int i = 0; i < 6; i++) begin
            step();
            tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
                fails++; $display("FAIL midrst_after%0d: got q=%h busy=%b done=%b expected 00 0 0", i, bus.q, bus.busy, bus.done); end
        end
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        load(8'h07);
        tests++; if (parity !== 1'b1) begin fails++; $display("FAIL parity_07: got %b expected 1", parity); end
        load(8'h03);
        tests++; if (parity !== 1'b0) begin fails++; $display("FAIL parity_03: got %b expected 0", parity); end
    endtask
`endif

    initial begin
        bus.mode = 3'b000;
        bus.data_in = '0;
        bus.serial_in_left = 1'b0;
        bus.serial_in_right = 1'b0;
        bus.amt = '0;
        bus.dir = 1'b0;
        #1;
        test_reset();
        test_single();
        test_burst();
        test_burst_zero();
        test_burst_long();
        test_back_to_back();
        test_reset_mid();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
